sequential_divider: RTL and testbench

SEQUENTIAL_DIVIDER -- requirements
Module: sequential_divider

---
 rtl/sequential_divider.sv | 89 ++++++++
 tb/tb_sequential_divider.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/sequential_divider.sv
// sequential_divider: restoring unsigned divider, one quotient bit per cycle, MSB first.
// Divide-by-zero skips the calculation and reports all-ones quotient with the dividend as remainder.
module sequential_divider #(
  parameter int WIDTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_op1,
  input  logic [WIDTH-1:0] i_op2,
  output logic [WIDTH-1:0] o_quotient,
  output logic [WIDTH-1:0] o_remainder,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_div_by_zero
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_divisor;
  logic [WIDTH-1:0] r_rem;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_quotient;
  logic [WIDTH-1:0] r_remainder;
  logic             r_dbz;
  logic [WIDTH:0]   w_part;
  logic [WIDTH:0]   w_diff;
  logic             w_ge;
  logic [WIDTH-1:0] w_rem_nx;
  logic [WIDTH-1:0] w_acc_nx;
  // r_acc shifts the dividend out at the top while quotient bits enter at the bottom
  always_comb begin
    w_part   = {r_rem, r_acc[WIDTH-1]};
    w_diff   = w_part - {1'b0, r_divisor};
    w_ge     = w_part >= {1'b0, r_divisor};
    w_rem_nx = w_ge ? w_diff[WIDTH-1:0] : w_part[WIDTH-1:0];
    w_acc_nx = {r_acc[WIDTH-2:0], w_ge};
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= IDLE;
      r_acc       <= '0;
      r_divisor   <= '0;
      r_rem       <= '0;
      r_cnt       <= '0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_dbz       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (i_start) begin
          if (i_op2 == '0) begin
            r_quotient  <= '1;
            r_remainder <= i_op1;
            r_dbz       <= 1'b1;
            r_state     <= DONE;
          end else begin
            r_acc     <= i_op1;
            r_divisor <= i_op2;
            r_rem     <= '0;
            r_cnt     <= '0;
            r_state   <= CALC;
          end
        end
        CALC: begin
          r_acc <= w_acc_nx;
          r_rem <= w_rem_nx;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LAST) begin
            r_quotient  <= w_acc_nx;
            r_remainder <= w_rem_nx;
            r_dbz       <= 1'b0;
            r_state     <= DONE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  assign o_quotient    = r_quotient;
  assign o_remainder   = r_remainder;
  assign o_div_by_zero = r_dbz;
  assign o_busy        = r_state != IDLE;
  assign o_done        = r_state == DONE;
endmodule

// File: tb/tb_sequential_divider.sv
// tb_sequential_divider: directed vectors, multi-cycle corner sequences and an exhaustive sweep
module tb_sequential_divider;
  logic       i_clk = 1'b0;
  logic       i_rst_n = 1'b0;
  logic       i_start = 1'b0;
  logic [3:0] i_op1 = '0;
  logic [3:0] i_op2 = '0;
  logic [3:0] o_quotient;
  logic [3:0] o_remainder;
  logic       o_busy;
  logic       o_done;
  logic       o_div_by_zero;
  int checks = 0;
  int errors = 0;

  sequential_divider #(.WIDTH(4)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start),
    .i_op1(i_op1), .i_op2(i_op2),
    .o_quotient(o_quotient), .o_remainder(o_remainder),
    .o_busy(o_busy), .o_done(o_done), .o_div_by_zero(o_div_by_zero)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [3:0] a, b, q, r;
    logic       dbz;
    int         done_idx;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Starts a division on the next edge; cycle index 1 is the cycle right after the accepting edge.
  // inj > 0 pulses i_start with different operands at that cycle index to prove it is ignored.
  task automatic run_div(input logic [3:0] a, input logic [3:0] b, input int inj,
                         output logic [3:0] q, output logic [3:0] r, output logic dbz,
                         output int busy_cnt, output int done_cnt, output int done_idx,
                         output logic hold_err);
    logic [3:0] pq, pr;
    logic       pd;
    @(negedge i_clk);
    pq = o_quotient; pr = o_remainder; pd = o_div_by_zero;
    i_start = 1'b1; i_op1 = a; i_op2 = b;
    @(posedge i_clk);
    #1 i_start = 1'b0;
    busy_cnt = 0; done_cnt = 0; done_idx = 0; hold_err = 1'b0;
    q = 'x; r = 'x; dbz = 1'bx;
    for (int i = 1; i <= 9; i++) begin
      @(negedge i_clk);
      i_start = 1'b0;
      if (o_busy) busy_cnt++;
      if (o_done) begin
        done_cnt++;
        if (done_idx == 0) begin
          done_idx = i; q = o_quotient; r = o_remainder; dbz = o_div_by_zero;
        end
      end
      if (done_idx == 0 && (o_quotient != pq || o_remainder != pr || o_div_by_zero != pd))
        hold_err = 1'b1;
      if (i == inj) begin
        i_start = 1'b1; i_op1 = 4'd3; i_op2 = 4'd1;
      end
    end
  endtask

  vec_t vecs[$];
  logic [3:0] q, r;
  logic dbz, herr;
  int bc, dc, di;

  initial begin
    vecs.push_back('{4'd13, 4'd4, 4'd3,  4'd1,  1'b0, 5});
    vecs.push_back('{4'd15, 4'd1, 4'd15, 4'd0,  1'b0, 5});
    vecs.push_back('{4'd3,  4'd7, 4'd0,  4'd3,  1'b0, 5});
    vecs.push_back('{4'd0,  4'd5, 4'd0,  4'd0,  1'b0, 5});
    vecs.push_back('{4'd9,  4'd0, 4'hF,  4'd9,  1'b1, 1});
    vecs.push_back('{4'd8,  4'd2, 4'd4,  4'd0,  1'b0, 5});
    vecs.push_back('{4'd15, 4'd15,4'd1,  4'd0,  1'b0, 5});
    vecs.push_back('{4'd1,  4'd15,4'd0,  4'd1,  1'b0, 5});
    vecs.push_back('{4'd0,  4'd0, 4'hF,  4'd0,  1'b1, 1});
    vecs.push_back('{4'd14, 4'd3, 4'd4,  4'd2,  1'b0, 5});

    #12;
    chk("reset_outputs", {o_quotient, o_remainder, o_busy, o_done, o_div_by_zero}, 0);
    @(negedge i_clk);
    i_rst_n = 1'b1;

    foreach (vecs[k]) begin
      run_div(vecs[k].a, vecs[k].b, 0, q, r, dbz, bc, dc, di, herr);
      chk($sformatf("v%0d_quotient", k), q, vecs[k].q);
      chk($sformatf("v%0d_remainder", k), r, vecs[k].r);
      chk($sformatf("v%0d_dbz", k), dbz, vecs[k].dbz);
      chk($sformatf("v%0d_done_idx", k), di, vecs[k].done_idx);
      chk($sformatf("v%0d_done_cnt", k), dc, 1);
      chk($sformatf("v%0d_busy_cycles", k), bc, vecs[k].done_idx);
      chk($sformatf("v%0d_hold", k), herr, 0);
    end

    // start pulse and operand change during CALC must be ignored
    run_div(4'd12, 4'd5, 2, q, r, dbz, bc, dc, di, herr);
    chk("ign_quotient", q, 2);
    chk("ign_remainder", r, 2);
    chk("ign_done_idx", di, 5);
    chk("ign_done_cnt", dc, 1);

    // reset in the 2nd CALC cycle, with nonzero prior results, clears outputs without a clock
    run_div(4'd14, 4'd3, 0, q, r, dbz, bc, dc, di, herr);
    @(negedge i_clk);
    i_start = 1'b1; i_op1 = 4'd13; i_op2 = 4'd4;
    @(posedge i_clk);
    #1 i_start = 1'b0;
    @(posedge i_clk);
    #2 i_rst_n = 1'b0;
    #1 chk("rst_async_outputs", {o_quotient, o_remainder, o_busy, o_done, o_div_by_zero}, 0);
    i_start = 1'b1; i_op1 = 4'd5; i_op2 = 4'd1;
    @(posedge i_clk);
    #1 chk("rst_start_ignored", {o_busy, o_done, o_quotient}, 0);
    @(negedge i_clk);
    i_rst_n = 1'b1; i_start = 1'b0;
    dc = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge i_clk);
      if (o_done) dc++;
    end
    chk("rst_no_done", dc, 0);
    run_div(4'd7, 4'd3, 0, q, r, dbz, bc, dc, di, herr);
    chk("post_rst_quotient", q, 2);
    chk("post_rst_remainder", r, 1);
    chk("post_rst_done_idx", di, 5);

    // i_start held high: one result every WIDTH+2 cycles
    @(negedge i_clk);
    i_start = 1'b1; i_op1 = 4'd13; i_op2 = 4'd4;
    begin
      int first, second;
      first = -1; second = -1;
      for (int i = 0; i < 30 && second < 0; i++) begin
        @(negedge i_clk);
        if (o_done) begin
          if (first < 0) first = i; else second = i;
        end
      end
      chk("b2b_found", (first >= 0 && second >= 0) ? 1 : 0, 1);
      chk("b2b_period", second - first, 6);
    end
    i_start = 1'b0;
    repeat (8) @(negedge i_clk);

    // exhaustive sweep against reference model
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        int eq, er, ed;
        eq = (b == 0) ? 15 : a / b;
        er = (b == 0) ? a : a % b;
        ed = (b == 0) ? 1 : 0;
        run_div(4'(a), 4'(b), 0, q, r, dbz, bc, dc, di, herr);
        chk($sformatf("sweep_%0d_%0d", a, b), {q, r, dbz, 4'(di)},
            {4'(eq), 4'(er), 1'(ed), 4'((b == 0) ? 1 : 5)});
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
